// File: rtl/xlu_muldiv.sv
// Execute-stage multiply/divide unit owning the HI/LO pair, with a multi-cycle busy model.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining XLU_MADD_EN.
module xlu_muldiv #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  xlu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] xlu_out
);

    localparam logic [3:0] OpMult  = 4'b0000;
    localparam logic [3:0] OpMultu = 4'b0001;
    localparam logic [3:0] OpDiv   = 4'b0010;
    localparam logic [3:0] OpDivu  = 4'b0011;
    localparam logic [3:0] OpMthi  = 4'b0100;
    localparam logic [3:0] OpMtlo  = 4'b0101;
    localparam logic [3:0] OpMfhi  = 4'b0110;
    localparam logic [3:0] OpMflo  = 4'b0111;
`ifdef XLU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'b1001;
    localparam logic [3:0] OpMaddu = 4'b1010;
    localparam logic [3:0] OpMsub  = 4'b1011;
    localparam logic [3:0] OpMsubu = 4'b1100;
`endif

    localparam logic [4:0] MultN = 5'(MULT_CYCLES);
    localparam logic [4:0] DivN  = 5'(DIV_CYCLES);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mult, is_div, is_acc;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
`ifdef XLU_MADD_EN
    logic [63:0] acc_add_s, acc_add_u, acc_sub_s, acc_sub_u;
`endif

    always_comb begin
        is_mult = (xlu_op == OpMult) || (xlu_op == OpMultu);
        is_div  = (xlu_op == OpDiv) || (xlu_op == OpDivu);
`ifdef XLU_MADD_EN
        is_acc  = (xlu_op == OpMadd) || (xlu_op == OpMaddu) ||
                  (xlu_op == OpMsub) || (xlu_op == OpMsubu);
`else
        is_acc  = 1'b0;
`endif
        start   = (state_q == StIdle) && (is_mult || is_div || is_acc);
    end

    // Arithmetic works only on operands latched at the start edge.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        quot_s = 32'd0;
        rem_s  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (b_q != 32'd0) begin
            quot_s = $signed(a_q) / $signed(b_q);
            rem_s  = $signed(a_q) % $signed(b_q);
            quot_u = a_q / b_q;
            rem_u  = a_q % b_q;
        end
`ifdef XLU_MADD_EN
        acc_add_s = {hi_q, lo_q} + prod_s;
        acc_add_u = {hi_q, lo_q} + prod_u;
        acc_sub_s = {hi_q, lo_q} - prod_s;
        acc_sub_u = {hi_q, lo_q} - prod_u;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBusy;
                    cnt_d   = is_div ? DivN : MultN;
                    op_d    = xlu_op;
                    a_d     = A;
                    b_d     = B;
                end else if (xlu_op == OpMthi) begin
                    hi_d = A;
                end else if (xlu_op == OpMtlo) begin
                    lo_d = A;
                end
            end
            StBusy: begin
                if (cnt_q == 5'd1) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                    case (op_q)
                        OpMult:  {hi_d, lo_d} = prod_s;
                        OpMultu: {hi_d, lo_d} = prod_u;
                        // Divide by zero leaves HI/LO untouched.
                        OpDiv: begin
                            if (b_q != 32'd0) begin
                                lo_d = quot_s;
                                hi_d = rem_s;
                            end
                        end
                        OpDivu: begin
                            if (b_q != 32'd0) begin
                                lo_d = quot_u;
                                hi_d = rem_u;
                            end
                        end
`ifdef XLU_MADD_EN
                        OpMadd:  {hi_d, lo_d} = acc_add_s;
                        OpMaddu: {hi_d, lo_d} = acc_add_u;
                        OpMsub:  {hi_d, lo_d} = acc_sub_s;
                        OpMsubu: {hi_d, lo_d} = acc_sub_u;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        busy = (state_q == StBusy);
        HI   = hi_q;
        LO   = lo_q;
        if (xlu_op == OpMfhi) begin
            xlu_out = hi_q;
        end else if (xlu_op == OpMflo) begin
            xlu_out = lo_q;
        end else begin
            xlu_out = 32'd0;
        end
    end

endmodule

// File: doc/xlu_muldiv.md
Name: xlu_muldiv

Overview:
- Execute-stage multiply/divide unit that owns the HI/LO register pair.
- Sits directly downstream of the E-stage controller and consumes its 4-bit xlu_op, plus the forwarded rs/rt operands.
- Models multi-cycle mult/div latency with a busy flag that the hazard unit uses to stall md-class instructions in D.
- Supplies HI or LO to the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu/madd/maddu/msub/msubu (1..31)
- DIV_CYCLES, 10, busy duration for div/divu (1..31)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- xlu_op  input  4  E-stage op code: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo, 1000 none, 1001 madd, 1010 maddu, 1011 msub, 1100 msubu; others treated as none
- A  input  32  forwarded rs operand
- B  input  32  forwarded rt operand
- start  output  1  combinational; 1 when xlu_op is a mult/div/madd-class op and state is IDLE
- busy  output  1  registered; 1 while an operation is in flight
- HI  output  32  HI register
- LO  output  32  LO register
- xlu_out  output  32  combinational; HI when xlu_op=0110, LO when 0111, otherwise 0

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, counter=0, HI=0, LO=0, pending result=0. Reset mid-operation aborts the operation and HI/LO read 0.
- States:
  - IDLE: accepts ops.
  - BUSY: counter running; all incoming ops except mfhi/mflo reads are ignored (no effect on HI/LO or state).
- Start: an accepted op in cycle T has start=1 in T.
  - At the T edge: latch A and B, load counter with N (MULT_CYCLES or DIV_CYCLES), go to BUSY.
  - busy=1 in cycles T+1..T+N.
  - At the edge ending cycle T+N: write HI/LO and return to IDLE.
  - busy=0 in T+N+1, and new HI/LO are visible in T+N+1.
  - A new start may be accepted in T+N+1.
- Counter decrements once per cycle in BUSY; the transition to IDLE happens when the counter equals 1.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero: full busy period runs, HI and LO are left unchanged.
  - madd/maddu: {HI,LO} = {HI,LO} + product (signed/unsigned), 64-bit wraparound.
  - msub/msubu: {HI,LO} = {HI,LO} - product, 64-bit wraparound.
  - The accumulate ops use the HI/LO values at completion; these equal the values at start because mthi/mtlo are ignored during BUSY.
- mthi/mtlo, IDLE only: HI (or LO) = A at the T edge, visible in T+1. No busy assertion.
- mfhi/mflo: purely combinational read in any state. Returns the current register value, i.e. the pre-completion value while busy.
- Hazard contract: the D stage must stall any md-class instruction (mult/div/madd/mt/mf) while start|busy. Ops ignored in BUSY are a protocol violation and have no side effect.
- Operand-latching: A and B must be captured at the start edge. Changes on A/B during BUSY must not alter the result.

Optional Feature:
- Macro: XLU_MADD_EN.
- Defined: madd/maddu/msub/msubu are decoded as above, with MULT_CYCLES latency.
- Undefined: opcodes 1001..1100 are treated as none. start stays 0, and HI/LO and busy are unaffected.

Test Plan:
- Reset, then A=7, B=-3 with mult: start=1 at T, busy=1 for exactly 5 cycles. At T+6: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- divu A=100, B=7: busy 10 cycles, then LO=14, HI=2. Repeat with div A=-7, B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x12345678, then mflo/mfhi next cycle: xlu_out=0x12345678 for mfhi. Then div A=5, B=0: after 10 busy cycles HI/LO are unchanged.
- mult A=B=0x10000, then mthi A=1 issued at T+2 while busy: the mthi is ignored. Final HI=1, LO=0 (the product, not the mthi write). A/B changed during busy do not affect the result.
- With XLU_MADD_EN defined: set HI=0, LO=0xFFFFFFFF, then madd A=1, B=1 → HI=1, LO=0. Without the macro the same op leaves busy=0 and HI/LO unchanged.
- Assert reset_n=0 at T+3 of a div: busy=0, HI=LO=0 immediately. After release, a new mult starts normally.
